// File: rtl/m68k_async_mem_slave_if.sv
// m68k_async_mem_slave_if: asynchronous 68030-style bus between core and memory slave
interface m68k_async_mem_slave_if;
  logic [31:0] adr;
  logic [1:0]  size;
  logic        rwn;
  logic        asn;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [1:0]  dsackn;
  logic        stermn;
  logic        berrn;
  modport master (output adr, size, rwn, asn, wdata, input rdata, dsackn, stermn, berrn);
  modport slave  (input adr, size, rwn, asn, wdata, output rdata, dsackn, stermn, berrn);
endinterface

// File: rtl/m68k_async_mem_slave.sv
// m68k_async_mem_slave: byte-addressed memory slave with dynamic bus sizing, wait states and bus error
module m68k_async_mem_slave #(
  parameter int          ADDR_BITS   = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          PORT_WIDTH  = 32,
  parameter int          WAIT_STATES = 0,
  parameter bit          SYNC_MODE   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  m68k_async_mem_slave_if.slave bus,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_adr,
  input  logic [7:0]           load_data
);
  localparam int PB = PORT_WIDTH / 8;
  localparam logic [1:0] ACK = PORT_WIDTH == 32 ? 2'b00 : PORT_WIDTH == 16 ? 2'b01 : 2'b10;
  localparam logic [ADDR_BITS-1:0] UMASK = ~ADDR_BITS'(PB - 1);
  if (PORT_WIDTH != 8 && PORT_WIDTH != 16 && PORT_WIDTH != 32) begin : g_bad_width
    $error("PORT_WIDTH must be 8, 16 or 32");
  end
  if (SYNC_MODE && PORT_WIDTH != 32) begin : g_bad_sync
    $error("SYNC_MODE requires PORT_WIDTH=32");
  end
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_TERM} state_t;
  state_t               state;
  logic [3:0]           cnt;
  logic [7:0]           mem [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] off;
  logic [ADDR_BITS-1:0] ubase;
  logic [ADDR_BITS-1:0] wa [4];
  logic [7:0]           wd [4];
  logic [3:0]           we;
  logic [2:0]           po;
  logic [2:0]           sb;
  logic [2:0]           lim;
  logic [2:0]           nb;
  logic                 hit;
  logic                 go;
  logic [31:0]          rd;
  assign off   = bus.adr[ADDR_BITS-1:0];
  assign ubase = off & UMASK;
  assign hit   = bus.adr[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS];
  assign go    = state == S_WAIT && !bus.asn && cnt == 4'd0;
  assign po    = {1'b0, off[1:0] & 2'(PB - 1)};
  assign sb    = bus.size == 2'b00 ? 3'd4 : {1'b0, bus.size};
  assign lim   = 3'(PB) - po;
  assign nb    = sb < lim ? sb : lim;
  for (genvar j = 0; j < 4; j++) begin : g_lane
    assign wa[j] = ubase + ADDR_BITS'(j);
    assign wd[j] = bus.wdata[31-8*j -: 8];
    assign we[j] = go && hit && !bus.rwn && 3'(j) >= po && 3'(j) < po + nb;
  end
  assign rd = PB == 4 ? {mem[wa[0]], mem[wa[1]], mem[wa[2]], mem[wa[3]]} :
              PB == 2 ? {mem[wa[0]], mem[wa[1]], 16'h0} : {mem[wa[0]], 24'h0};
  // Backdoor byte loads first, then bus lanes, so the bus wins a same-edge collision
  always_ff @(posedge clk) begin
    if (load_en) mem[load_adr] <= load_data;
    for (int k = 0; k < 4; k++) if (we[k]) mem[wa[k]] <= wd[k];
  end
  // Bus cycle sequencer: strobe sample, wait-state countdown, termination hold until strobe release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      bus.rdata <= 32'h0;
      bus.dsackn <= 2'b11;
      bus.stermn <= 1'b1;
      bus.berrn <= 1'b1;
    end else begin
      case (state)
        S_IDLE: if (!bus.asn) begin
          state <= S_WAIT;
          cnt   <= 4'(WAIT_STATES);
        end
        S_WAIT: if (bus.asn) state <= S_IDLE;
        else if (cnt == 4'd0) begin
          state     <= S_TERM;
          bus.rdata <= hit && bus.rwn ? rd : 32'h0;
          if (!hit) bus.berrn <= 1'b0;
          else if (SYNC_MODE) bus.stermn <= 1'b0;
          else bus.dsackn <= ACK;
        end else cnt <= cnt - 4'd1;
        default: begin
          bus.stermn <= 1'b1;
          if (SYNC_MODE && !bus.stermn) bus.rdata <= 32'h0;
          if (bus.asn) begin
            state      <= S_IDLE;
            bus.rdata  <= 32'h0;
            bus.dsackn <= 2'b11;
            bus.berrn  <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_m68k_async_mem_slave.sv
// tb_m68k_async_mem_slave: randomized scoreboard bench over four slave configurations
module tb_m68k_async_mem_slave;
  localparam int N = 4;
  localparam int PWS [N] = '{32, 16, 8, 32};
  localparam int WSS [N] = '{0, 3, 1, 2};
  localparam logic [31:0] BAS [N] = '{32'h0, 32'h0, 32'h1000, 32'h4000};
  localparam bit SYN [N] = '{1'b0, 1'b0, 1'b0, 1'b1};
  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  dsackn;
    logic        stermn;
    logic        berrn;
    int          start;
    int          lat;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [31:0] adr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [1:0] size = 2'b00;
  logic rwn = 1'b1;
  logic asn = 1'b1;
  logic load_en = 1'b0;
  logic [9:0] load_adr = 10'h0;
  logic [7:0] load_data = 8'h0;
  int sel = 0;
  int cyc = 0;
  int checks = 0;
  int errs = 0;
  logic [31:0] rd_a [N];
  logic [1:0] ds_a [N];
  logic st_a [N];
  logic be_a [N];
  logic [31:0] o_rdata;
  logic [1:0] o_dsackn;
  logic o_stermn, o_berrn, o_act;
  logic [7:0] mm [N][1024];
  exp_t q [$];
  bit prev_act = 1'b0;
  bit pend_sync = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < N; g++) begin : d
    m68k_async_mem_slave_if b ();
    assign b.adr = adr;
    assign b.size = size;
    assign b.rwn = rwn;
    assign b.wdata = wdata;
    assign b.asn = sel == g ? asn : 1'b1;
    m68k_async_mem_slave #(.ADDR_BITS(10), .BASE_ADDR(BAS[g]), .PORT_WIDTH(PWS[g]),
                           .WAIT_STATES(WSS[g]), .SYNC_MODE(SYN[g])) u (
      .clk(clk), .rst_n(rst_n), .bus(b), .load_en(load_en && sel == g),
      .load_adr(load_adr), .load_data(load_data));
    assign rd_a[g] = b.rdata;
    assign ds_a[g] = b.dsackn;
    assign st_a[g] = b.stermn;
    assign be_a[g] = b.berrn;
  end
  assign o_rdata = rd_a[sel];
  assign o_dsackn = ds_a[sel];
  assign o_stermn = st_a[sel];
  assign o_berrn = be_a[sel];
  assign o_act = o_dsackn != 2'b11 || !o_stermn || !o_berrn;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h (cfg %0d, t=%0t)", nm, act, req, sel, $time);
    end
  endtask
  function automatic logic [1:0] code(input int pb);
    return pb == 4 ? 2'b00 : pb == 2 ? 2'b01 : 2'b10;
  endfunction
  // Reference: expected termination from address window, port size and byte-count rules; updates model memory
  function automatic exp_t mk_exp(input int s, input logic [31:0] a, input logic [1:0] sz, input logic rw,
                                  input logic [31:0] wd, input bit coll, input logic [7:0] ld);
    exp_t e;
    logic [31:0] b;
    int pb, off, po, n;
    bit h;
    b = BAS[s];
    pb = PWS[s] / 8;
    off = int'(a[9:0]);
    h = a[31:10] == b[31:10];
    e.rdata = 32'h0;
    e.start = cyc;
    e.lat = WSS[s] + 2;
    e.berrn = h;
    e.stermn = !(h && SYN[s]);
    e.dsackn = (h && !SYN[s]) ? code(pb) : 2'b11;
    if (h && rw) for (int k = 0; k < pb; k++) e.rdata[31-8*k -: 8] = mm[s][off / pb * pb + k];
    if (coll) mm[s][off] = ld;
    if (h && !rw) begin
      po = off % pb;
      n = sz == 2'b00 ? 4 : int'(sz);
      if (n > pb - po) n = pb - po;
      for (int k = 0; k < n; k++) mm[s][off + k] = wd[31-8*(po+k) -: 8];
    end
    return e;
  endfunction
  task automatic load(input int s, input int a, input logic [7:0] v);
    @(negedge clk);
    sel = s;
    load_en = 1'b1;
    load_adr = 10'(a);
    load_data = v;
    mm[s][a] = v;
    @(negedge clk);
    load_en = 1'b0;
  endtask
  task automatic txn(input int s, input logic [31:0] a, input logic [1:0] sz, input logic rw,
                     input logic [31:0] wd, input int hold, input int abort_at, input bit coll);
    logic [7:0] ld;
    bit done;
    ld = 8'($urandom);
    @(negedge clk);
    sel = s;
    adr = a;
    size = sz;
    rwn = rw;
    wdata = wd;
    asn = 1'b0;
    if (abort_at > 0) begin
      repeat (abort_at) @(negedge clk);
      asn = 1'b1;
      repeat (WSS[s] + 3) @(negedge clk);
    end else begin
      q.push_back(mk_exp(s, a, sz, rw, wd, coll, ld));
      done = 1'b0;
      load_adr = a[9:0];
      load_data = ld;
      for (int i = 1; i <= 40 && !done; i++) begin
        @(negedge clk);
        load_en = coll && i == WSS[s] + 1;
        done = o_act;
      end
      load_en = 1'b0;
      chk("term_seen", 64'(done), 64'd1);
      repeat (hold) @(negedge clk);
      asn = 1'b1;
      @(negedge clk);
      chk("release", 64'({o_dsackn, o_stermn, o_berrn, o_rdata}), 64'({2'b11, 1'b1, 1'b1, 32'h0}));
    end
  endtask
  // Monitor: pop an expectation at each new termination and check response and latency
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (pend_sync) begin
      chk("sterm_pulse", 64'({o_dsackn, o_stermn, o_rdata}), 64'({2'b11, 1'b1, 32'h0}));
      pend_sync = 1'b0;
    end else if (o_act && !prev_act) begin
      if (q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_term actual dsackn=%b stermn=%b berrn=%b required idle (cfg %0d)",
                 o_dsackn, o_stermn, o_berrn, sel);
      end else begin
        e = q.pop_front();
        chk("resp", 64'({o_dsackn, o_stermn, o_berrn, o_rdata}), 64'({e.dsackn, e.stermn, e.berrn, e.rdata}));
        chk("latency", 64'(cyc - e.start), 64'(e.lat));
        pend_sync = !e.stermn;
      end
    end
    prev_act = o_act;
  end
  // Stimulus: reset, spec scenarios, collision and reset corner cases, then random traffic
  initial begin
    int s, ab;
    logic [31:0] a, b;
    bit done;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      sel = i;
      #1 chk("reset_state", 64'({o_dsackn, o_stermn, o_berrn, o_rdata}), 64'({2'b11, 1'b1, 1'b1, 32'h0}));
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 1024; j++) begin
        @(negedge clk);
        sel = i;
        load_en = 1'b1;
        load_adr = 10'(j);
        load_data = 8'($urandom);
        mm[i][j] = load_data;
      end
    @(negedge clk);
    load_en = 1'b0;
    load(0, 'h10, 8'h4E);
    load(0, 'h11, 8'h71);
    load(0, 'h12, 8'h4E);
    load(0, 'h13, 8'h75);
    txn(0, 32'h10, 2'b00, 1'b1, 32'h0, 1, 0, 1'b0);
    chk("boot_word", 64'({mm[0][16], mm[0][17], mm[0][18], mm[0][19]}), 64'h4E714E75);
    txn(1, 32'h0, 2'b00, 1'b1, 32'h0, 0, 0, 1'b0);
    txn(1, 32'h0, 2'b00, 1'b0, 32'hDEADBEEF, 0, 2, 1'b0);
    txn(1, 32'h0, 2'b00, 1'b1, 32'h0, 0, 0, 1'b0);
    txn(1, 32'h21, 2'b00, 1'b0, 32'hAABBCCDD, 0, 0, 1'b0);
    txn(1, 32'h22, 2'b01, 1'b0, 32'h55000000, 0, 0, 1'b0);
    txn(1, 32'h20, 2'b10, 1'b1, 32'h0, 0, 0, 1'b0);
    txn(1, 32'h22, 2'b10, 1'b1, 32'h0, 0, 0, 1'b0);
    txn(2, 32'h1003, 2'b00, 1'b1, 32'h0, 0, 0, 1'b0);
    txn(2, 32'h1004, 2'b10, 1'b0, 32'h12345678, 0, 0, 1'b0);
    txn(2, 32'h1004, 2'b01, 1'b1, 32'h0, 0, 0, 1'b0);
    txn(2, 32'h1005, 2'b01, 1'b1, 32'h0, 0, 0, 1'b0);
    txn(2, 32'h00FF0000, 2'b00, 1'b0, 32'h01020304, 2, 0, 1'b0);
    txn(0, 32'h00FF0000, 2'b00, 1'b1, 32'h0, 0, 0, 1'b0);
    txn(0, 32'h31, 2'b00, 1'b0, 32'h11223344, 0, 0, 1'b0);
    txn(0, 32'h30, 2'b00, 1'b1, 32'h0, 0, 0, 1'b0);
    txn(0, 32'h80, 2'b01, 1'b0, 32'hA5000000, 0, 0, 1'b1);
    txn(0, 32'h80, 2'b00, 1'b1, 32'h0, 0, 0, 1'b0);
    txn(3, 32'h4008, 2'b00, 1'b1, 32'h0, 0, 0, 1'b0);
    txn(3, 32'h4009, 2'b00, 1'b1, 32'h0, 2, 0, 1'b0);
    @(negedge clk);
    sel = 3;
    adr = 32'h4020;
    size = 2'b00;
    rwn = 1'b0;
    wdata = 32'hCAFEF00D;
    asn = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk("reset_wait_idle", 64'({o_dsackn, o_stermn, o_berrn, o_rdata}), 64'({2'b11, 1'b1, 1'b1, 32'h0}));
    @(negedge clk);
    asn = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    txn(3, 32'h4020, 2'b00, 1'b1, 32'h0, 0, 0, 1'b0);
    @(negedge clk);
    sel = 0;
    adr = 32'h40;
    size = 2'b00;
    rwn = 1'b1;
    asn = 1'b0;
    q.push_back(mk_exp(0, 32'h40, 2'b00, 1'b1, 32'h0, 1'b0, 8'h0));
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      done = o_act;
    end
    chk("term_seen", 64'(done), 64'd1);
    #1 rst_n = 1'b0;
    #1 chk("reset_term_idle", 64'({o_dsackn, o_stermn, o_berrn, o_rdata}), 64'({2'b11, 1'b1, 1'b1, 32'h0}));
    @(negedge clk);
    asn = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int t = 0; t < 300; t++) begin
      s = $urandom_range(0, N - 1);
      b = BAS[s];
      a = b | 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 9) == 0) begin
        a = $urandom;
        if (a[31:10] == b[31:10]) a[31] = ~a[31];
      end
      ab = (WSS[s] > 0 && $urandom_range(0, 7) == 0) ? $urandom_range(1, WSS[s]) : 0;
      txn(s, a, 2'($urandom), 1'($urandom), $urandom, $urandom_range(0, 2), ab, $urandom_range(0, 5) == 0);
    end
    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
